// File: rtl/mips_pkg.sv
// Shared MIPS32 multicycle control definitions: opcodes, control-field encodings,
// controller state enum and the packed control word. JAL support: MAINDEC_JAL_EN.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEXE,
        S_ALUWB,
        S_BRANCH,
        S_IEXE,
        S_IWB,
        S_JUMP,
`ifdef MAINDEC_JAL_EN
        S_JAL,
`endif
        S_FAULT
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] memtoreg;
        logic [1:0] regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
    } ctl_t;

    // States in which the memory handshake is live and the watchdog runs.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-wait watchdog: counts consecutive not-ready cycles within one memory
// state and flags expiry when the WAIT_MAX-th such cycle is reached.
module mem_watchdog #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic active,
    input  logic ready,
    input  logic restart,
    output logic expire
);

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_MAX - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // A fresh count starts on every state change, so each memory state gets its own budget.
    always_comb begin
        count_d = 8'd0;
        if (active && !ready && !restart) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = active && !ready && (count_q == LAST_WAIT);

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS32 main controller (Moore FSM with memory stall and watchdog).
// Define MAINDEC_JAL_EN to decode opcode 000011 as JAL; otherwise it traps as illegal.
module mc_maindec
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       branch_ne,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] memtoreg,
    output logic [1:0] regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       extop,
    output logic [2:0] aluop,
    output logic [1:0] pcsrc,
    output logic       mem_timeout,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;
    state_t decode_target;
    logic   op_legal;
    logic   mem_timeout_q;
    logic   illegal_op_q;
    logic   wd_active;
    logic   wd_restart;
    logic   wd_expire;
    ctl_t   ctl;

    assign wd_active  = is_mem_wait(state_q);
    assign wd_restart = (state_d != state_q);

    mem_watchdog #(
        .WAIT_MAX (WAIT_MAX)
    ) u_mem_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .active  (wd_active),
        .ready   (mem_ready),
        .restart (wd_restart),
        .expire  (wd_expire)
    );

    always_comb begin
        decode_target = S_FAULT;
        op_legal      = 1'b1;
        case (op)
            OP_LW, OP_SW:                       decode_target = S_MEMADR;
            OP_RTYPE:                           decode_target = S_RTEXE;
            OP_BEQ, OP_BNE:                     decode_target = S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  decode_target = S_IEXE;
            OP_J:                               decode_target = S_JUMP;
`ifdef MAINDEC_JAL_EN
            OP_JAL:                             decode_target = S_JAL;
`endif
            default: begin
                decode_target = S_FAULT;
                op_legal      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            mem_timeout_q <= 1'b0;
            illegal_op_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wd_expire) begin
                mem_timeout_q <= 1'b1;
            end
            if ((state_q == S_DECODE) && !op_legal) begin
                illegal_op_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (wd_expire) begin
                    state_d = S_FAULT;
                end else if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = decode_target;
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (wd_expire) begin
                    state_d = S_FAULT;
                end else if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (wd_expire) begin
                    state_d = S_FAULT;
                end else if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_RTEXE:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEXE:   state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MAINDEC_JAL_EN
            S_JAL:    state_d = S_FETCH;
`endif
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control word: everything idles low except extop, which defaults to sign extension.
    always_comb begin
        ctl       = '0;
        ctl.extop = 1'b1;
        case (state_q)
            S_IDLE, S_FAULT: ctl = '0;
            S_FETCH: begin
                ctl.memread = 1'b1;
                ctl.alusrcb = SRCB_FOUR;
                ctl.aluop   = ALU_ADD;
                ctl.pcsrc   = PC_ALU;
                ctl.irwrite = mem_ready;
                ctl.pcwrite = mem_ready;
            end
            S_DECODE: begin
                ctl.alusrcb = SRCB_IMMSH2;
                ctl.aluop   = ALU_ADD;
            end
            S_MEMADR: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = SRCB_IMM;
                ctl.aluop   = ALU_ADD;
            end
            S_MEMRD: begin
                ctl.iord    = 1'b1;
                ctl.memread = 1'b1;
            end
            S_MEMWB: begin
                ctl.regwrite = 1'b1;
                ctl.memtoreg = M2R_MDR;
                ctl.regdst   = RD_RT;
            end
            S_MEMWR: begin
                ctl.iord     = 1'b1;
                ctl.memwrite = 1'b1;
            end
            S_RTEXE: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = SRCB_RT;
                ctl.aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctl.regwrite = 1'b1;
                ctl.regdst   = RD_RD;
                ctl.memtoreg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                ctl.alusrca   = 1'b1;
                ctl.aluop     = ALU_SUB;
                ctl.pcsrc     = PC_ALUOUT;
                ctl.branch    = (op == OP_BEQ);
                ctl.branch_ne = (op == OP_BNE);
            end
            S_IEXE: begin
                ctl.alusrca = 1'b1;
                ctl.alusrcb = SRCB_IMM;
                case (op)
                    OP_ANDI: begin
                        ctl.aluop = ALU_AND;
                        ctl.extop = 1'b0;
                    end
                    OP_ORI: begin
                        ctl.aluop = ALU_OR;
                        ctl.extop = 1'b0;
                    end
                    OP_SLTI: ctl.aluop = ALU_SLT;
                    default: ctl.aluop = ALU_ADD;
                endcase
            end
            S_IWB: begin
                ctl.regwrite = 1'b1;
                ctl.regdst   = RD_RT;
            end
            S_JUMP: begin
                ctl.pcwrite = 1'b1;
                ctl.pcsrc   = PC_JUMP;
            end
`ifdef MAINDEC_JAL_EN
            // The PC register already holds PC+4 from FETCH, so it is the link value.
            S_JAL: begin
                ctl.pcwrite  = 1'b1;
                ctl.pcsrc    = PC_JUMP;
                ctl.regwrite = 1'b1;
                ctl.regdst   = RD_RA;
                ctl.memtoreg = M2R_PC;
            end
`endif
            default: ctl = '0;
        endcase
    end

    assign pcwrite     = ctl.pcwrite;
    assign branch      = ctl.branch;
    assign branch_ne   = ctl.branch_ne;
    assign iord        = ctl.iord;
    assign memread     = ctl.memread;
    assign memwrite    = ctl.memwrite;
    assign irwrite     = ctl.irwrite;
    assign memtoreg    = ctl.memtoreg;
    assign regdst      = ctl.regdst;
    assign regwrite    = ctl.regwrite;
    assign alusrca     = ctl.alusrca;
    assign alusrcb     = ctl.alusrcb;
    assign extop       = ctl.extop;
    assign aluop       = ctl.aluop;
    assign pcsrc       = ctl.pcsrc;
    assign mem_timeout = mem_timeout_q;
    assign illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec: per-cycle control-word vectors for each instruction
// class, memory stalls, watchdog timeout/boundary, illegal opcode and async reset.
module tb_mc_maindec;

    logic       clk;
    logic       resetn;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, branch, branch_ne, iord, memread, memwrite, irwrite;
    logic [1:0] memtoreg, regdst, alusrcb, pcsrc;
    logic       regwrite, alusrca, extop, mem_timeout, illegal_op;
    logic [2:0] aluop;

    int checks = 0;
    int errors = 0;

    mc_maindec #(
        .WAIT_MAX (15)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .op          (op),
        .mem_ready   (mem_ready),
        .pcwrite     (pcwrite),
        .branch      (branch),
        .branch_ne   (branch_ne),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memtoreg    (memtoreg),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .extop       (extop),
        .aluop       (aluop),
        .pcsrc       (pcsrc),
        .mem_timeout (mem_timeout),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word: {pcw,br,bne,iord,mrd,mwr,irw}, {memtoreg,regdst}, {regwrite,alusrca},
    // alusrcb, extop, aluop, pcsrc.
    logic [20:0] obs;
    assign obs = {pcwrite, branch, branch_ne, iord, memread, memwrite, irwrite,
                  memtoreg, regdst, regwrite, alusrca, alusrcb, extop, aluop, pcsrc};

    localparam logic [20:0] E_ZERO    = 21'b0;
    localparam logic [20:0] E_FETCH_R = {7'b1000101, 4'b0000, 2'b00, 2'b01, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_FETCH_W = {7'b0000100, 4'b0000, 2'b00, 2'b01, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_DECODE  = {7'b0000000, 4'b0000, 2'b00, 2'b11, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_MEMADR  = {7'b0000000, 4'b0000, 2'b01, 2'b10, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_MEMRD   = {7'b0001100, 4'b0000, 2'b00, 2'b00, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_MEMWB   = {7'b0000000, 4'b0100, 2'b10, 2'b00, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_MEMWR   = {7'b0001010, 4'b0000, 2'b00, 2'b00, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_RTEXE   = {7'b0000000, 4'b0000, 2'b01, 2'b00, 1'b1, 3'b010, 2'b00};
    localparam logic [20:0] E_ALUWB   = {7'b0000000, 4'b0001, 2'b10, 2'b00, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_BEQ     = {7'b0100000, 4'b0000, 2'b01, 2'b00, 1'b1, 3'b001, 2'b01};
    localparam logic [20:0] E_BNE     = {7'b0010000, 4'b0000, 2'b01, 2'b00, 1'b1, 3'b001, 2'b01};
    localparam logic [20:0] E_ADDI    = {7'b0000000, 4'b0000, 2'b01, 2'b10, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_ANDI    = {7'b0000000, 4'b0000, 2'b01, 2'b10, 1'b0, 3'b011, 2'b00};
    localparam logic [20:0] E_ORI     = {7'b0000000, 4'b0000, 2'b01, 2'b10, 1'b0, 3'b100, 2'b00};
    localparam logic [20:0] E_SLTI    = {7'b0000000, 4'b0000, 2'b01, 2'b10, 1'b1, 3'b101, 2'b00};
    localparam logic [20:0] E_IWB     = {7'b0000000, 4'b0000, 2'b10, 2'b00, 1'b1, 3'b000, 2'b00};
    localparam logic [20:0] E_JUMP    = {7'b1000000, 4'b0000, 2'b00, 2'b00, 1'b1, 3'b000, 2'b10};
    localparam logic [20:0] E_JAL     = {7'b1000000, 4'b1010, 2'b10, 2'b00, 1'b1, 3'b000, 2'b10};

    // Hold reset across two edges, release on a falling edge; FSM sits in IDLE afterwards.
    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        op        = 6'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        #2;
        checks++;
        if (obs !== E_ZERO || mem_timeout !== 1'b0 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ctl=%b flags=%b%b want ctl=%b flags=00", obs, mem_timeout, illegal_op, E_ZERO);
        end
        do_reset();
        #1;
        checks++;
        if (obs !== E_ZERO) begin
            errors++;
            $display("FAIL reset_idle: ctl=%b want %b", obs, E_ZERO);
        end
        @(posedge clk);
        #2;
        checks++;
        if (obs !== E_FETCH_R) begin
            errors++;
            $display("FAIL reset_to_fetch: ctl=%b want %b", obs, E_FETCH_R);
        end
        $display("txn reset: checked");
    endtask

    task automatic test_add();
        logic [20:0] exp_v [5];
        int rw_cycles;
        exp_v = '{E_FETCH_R, E_DECODE, E_RTEXE, E_ALUWB, E_FETCH_R};
        rw_cycles = 0;
        do_reset();
        op = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL add cycle %0d: ctl=%b want %b", i + 1, obs, exp_v[i]);
            end
            if (i < 4 && regwrite === 1'b1) rw_cycles++;
        end
        checks++;
        if (rw_cycles !== 1) begin
            errors++;
            $display("FAIL add_regwrite_count: got %0d want 1", rw_cycles);
        end
        $display("txn ADD: 4 cycles checked");
    endtask

    task automatic test_lw_stall();
        logic [20:0] exp_v [9];
        logic        rdy_v [9];
        int irw_cnt, rw_cnt;
        exp_v = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB, E_FETCH_R};
        rdy_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        irw_cnt = 0;
        rw_cnt  = 0;
        do_reset();
        op = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1 mem_ready = rdy_v[i];
            #1;
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: ctl=%b want %b", i + 1, obs, exp_v[i]);
            end
            if (i < 8) begin
                if (irwrite === 1'b1) irw_cnt++;
                if (regwrite === 1'b1) rw_cnt++;
            end
        end
        checks++;
        if (irw_cnt !== 1 || rw_cnt !== 1) begin
            errors++;
            $display("FAIL lw_pulse_counts: irwrite=%0d regwrite=%0d want 1 and 1", irw_cnt, rw_cnt);
        end
        $display("txn LW: 8 cycles with 3 wait cycles checked");
    endtask

    task automatic test_sw();
        logic [20:0] exp_v [5];
        logic        rdy_v [5];
        exp_v = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH_R};
        rdy_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        op = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 mem_ready = rdy_v[i];
            #1;
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL sw cycle %0d: ctl=%b want %b", i + 1, obs, exp_v[i]);
            end
        end
        $display("txn SW: 4 cycles checked");
    endtask

    task automatic test_bne_ori();
        logic [20:0] exp_v [8];
        logic [5:0]  op_v  [8];
        exp_v = '{E_FETCH_R, E_DECODE, E_BNE, E_FETCH_R, E_DECODE, E_ORI, E_IWB, E_FETCH_R};
        op_v  = '{6'b000101, 6'b000101, 6'b000101, 6'b001101, 6'b001101, 6'b001101, 6'b001101, 6'b000000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            op        = op_v[i];
            mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL bne_ori cycle %0d: ctl=%b want %b", i + 1, obs, exp_v[i]);
            end
        end
        $display("txn BNE+ORI: 3 + 4 cycles checked");
    endtask

    task automatic test_back_to_back();
        logic [20:0] exp_v [19];
        logic [5:0]  op_v  [19];
        exp_v = '{E_FETCH_R, E_DECODE, E_BEQ,
                  E_FETCH_R, E_DECODE, E_JUMP,
                  E_FETCH_R, E_DECODE, E_ANDI, E_IWB,
                  E_FETCH_R, E_DECODE, E_SLTI, E_IWB,
                  E_FETCH_R, E_DECODE, E_ADDI, E_IWB,
                  E_FETCH_R};
        op_v  = '{6'b000100, 6'b000100, 6'b000100,
                  6'b000010, 6'b000010, 6'b000010,
                  6'b001100, 6'b001100, 6'b001100, 6'b001100,
                  6'b001010, 6'b001010, 6'b001010, 6'b001010,
                  6'b001000, 6'b001000, 6'b001000, 6'b001000,
                  6'b000000};
        do_reset();
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            op        = op_v[i];
            mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL b2b cycle %0d op=%b: ctl=%b want %b", i + 1, op_v[i], obs, exp_v[i]);
            end
        end
        $display("txn BEQ,J,ANDI,SLTI,ADDI: back-to-back checked");
    endtask

    task automatic test_timeout();
        do_reset();
        op = 6'b000000;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 mem_ready = 1'b0;
            #1;
            checks++;
            if (obs !== E_FETCH_W || mem_timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d: ctl=%b to=%b want %b to=0", i + 1, obs, mem_timeout, E_FETCH_W);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 mem_ready = 1'b1;
            #1;
            checks++;
            if (obs !== E_ZERO || mem_timeout !== 1'b1 || illegal_op !== 1'b0) begin
                errors++;
                $display("FAIL timeout_fault %0d: ctl=%b to=%b ill=%b want ctl=0 to=1 ill=0", i, obs, mem_timeout, illegal_op);
            end
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (mem_timeout !== 1'b0 || obs !== E_ZERO) begin
            errors++;
            $display("FAIL timeout_clear: to=%b ctl=%b want to=0 ctl=0", mem_timeout, obs);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (obs !== E_FETCH_R || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_restart: ctl=%b to=%b want %b to=0", obs, mem_timeout, E_FETCH_R);
        end
        $display("txn FETCH timeout: fault after 15 wait cycles checked");
    endtask

    task automatic test_wait_boundary();
        do_reset();
        op = 6'b000000;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 mem_ready = (i == 14);
            #1;
        end
        checks++;
        if (obs !== E_FETCH_R) begin
            errors++;
            $display("FAIL boundary_complete: ctl=%b want %b", obs, E_FETCH_R);
        end
        @(posedge clk);
        #2;
        checks++;
        if (obs !== E_DECODE || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL boundary_no_fault: ctl=%b to=%b want %b to=0", obs, mem_timeout, E_DECODE);
        end
        $display("txn FETCH ready on last wait cycle: no fault checked");
    endtask

    task automatic test_reset_abort();
        logic [20:0] exp_v [4];
        logic        rdy_v [4];
        exp_v = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR};
        rdy_v = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        op = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 mem_ready = rdy_v[i];
            #1;
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL abort_setup cycle %0d: ctl=%b want %b", i + 1, obs, exp_v[i]);
            end
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (memwrite !== 1'b0 || obs !== E_ZERO) begin
            errors++;
            $display("FAIL abort_memwrite: memwrite=%b ctl=%b want 0", memwrite, obs);
        end
        @(negedge clk);
        resetn = 1'b1;
        $display("txn SW aborted by reset: checked");
    endtask

    task automatic test_opcode_000011();
        do_reset();
        op = 6'b000011;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        checks++;
        if (obs !== E_DECODE || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL op3_decode: ctl=%b ill=%b want %b ill=0", obs, illegal_op, E_DECODE);
        end
        @(posedge clk);
        #2;
`ifdef MAINDEC_JAL_EN
        checks++;
        if (obs !== E_JAL || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL jal_state: ctl=%b ill=%b want %b ill=0", obs, illegal_op, E_JAL);
        end
        @(posedge clk);
        #2;
        checks++;
        if (obs !== E_FETCH_R) begin
            errors++;
            $display("FAIL jal_return: ctl=%b want %b", obs, E_FETCH_R);
        end
`else
        checks++;
        if (obs !== E_ZERO || illegal_op !== 1'b1 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL op3_illegal: ctl=%b ill=%b to=%b want ctl=0 ill=1 to=0", obs, illegal_op, mem_timeout);
        end
`endif
        $display("txn opcode 000011: checked");
    endtask

    task automatic test_illegal();
        do_reset();
        op = 6'b111111;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (obs !== E_ZERO || illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL illegal_fault: ctl=%b ill=%b want ctl=0 ill=1", obs, illegal_op);
        end
        op = 6'b000000;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (obs !== E_ZERO || illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: ctl=%b ill=%b want ctl=0 ill=1", obs, illegal_op);
        end
        $display("txn opcode 111111: illegal trap checked");
    endtask

    initial begin
        resetn    = 1'b0;
        op        = 6'b0;
        mem_ready = 1'b1;
        test_reset();
        test_add();
        test_lw_stall();
        test_sw();
        test_bne_ori();
        test_back_to_back();
        test_timeout();
        test_wait_boundary();
        test_reset_abort();
        test_opcode_000011();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: bench did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main controller for the MIPS32 datapath, succeeding the single-cycle opcode decoder. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback, and stalls on a variable-latency memory handshake. It adds a memory-wait watchdog, an illegal-opcode trap, ANDI/ORI/SLTI/BNE and optional JAL. It sits between the instruction register's opcode field and the shared-memory multicycle datapath.

## Interface
- `WAIT_MAX`, 15: maximum consecutive cycles with `mem_ready` low in one memory state before a timeout fault; legal range 1..255.
- `clk` input 1: clock; one clock domain.
- `resetn` input 1: reset, asynchronous, active-low.
- `op` input 6: opcode, IR[31:26]; valid from DECODE onward.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pcwrite` output 1: unconditional PC load.
- `branch` output 1: PC load if ALU zero (BEQ).
- `branch_ne` output 1: PC load if not zero (BNE).
- `iord` output 1: memory address source; 0 = PC, 1 = ALUOut.
- `memread` output 1: memory read request.
- `memwrite` output 1: memory write request.
- `irwrite` output 1: IR load.
- `memtoreg` output 2: write-data source; 00 = ALUOut, 01 = MDR, 10 = PC.
- `regdst` output 2: destination register; 00 = rt, 01 = rd, 10 = $31.
- `regwrite` output 1: register file write.
- `alusrca` output 1: ALU A source; 0 = PC, 1 = rs.
- `alusrcb` output 2: ALU B source; 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- `extop` output 1: immediate extension; 1 = sign, 0 = zero.
- `aluop` output 3: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
- `pcsrc` output 2: PC source; 00 = ALU, 01 = ALUOut, 10 = jump target.
- `mem_timeout` output 1: sticky watchdog fault.
- `illegal_op` output 1: sticky illegal-opcode fault.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ALUWB, BRANCH, IEXE, IWB, JUMP, JAL, FAULT.
- Outputs are a pure function of state, `op` and `mem_ready`.
- Unlisted outputs are 0. `extop` defaults to 1.
- IDLE: all outputs 0. Goes to FETCH on the next edge.
- FETCH: `memread`=1, `alusrcb`=01, `aluop`=000, `pcsrc`=00. `irwrite`=`pcwrite`=`mem_ready`. Goes to DECODE when `mem_ready` is high, otherwise stays.
- DECODE: `alusrcb`=11, `aluop`=000 (branch target).
  - 100011 / 101011 → MEMADR.
  - 000000 → RTEXE.
  - 000100 / 000101 → BRANCH.
  - 001000 / 001100 / 001101 / 001010 → IEXE.
  - 000010 → JUMP.
  - 000011 → JAL when `MAINDEC_JAL_EN` is defined.
  - Any other opcode → FAULT with `illegal_op` set.
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=000. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: `iord`=1, `memread`=1. Waits for `mem_ready`, then → MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=01, `regdst`=00. → FETCH.
- MEMWR: `iord`=1, `memwrite`=1. Waits for `mem_ready`, then → FETCH.
- RTEXE: `alusrca`=1, `alusrcb`=00, `aluop`=010. → ALUWB.
- ALUWB: `regwrite`=1, `regdst`=01. → FETCH.
- BRANCH: `alusrca`=1, `aluop`=001, `pcsrc`=01. `branch`=(op==000100), `branch_ne`=(op==000101). → FETCH.
- IEXE: `alusrca`=1, `alusrcb`=10. → IWB.
  - `aluop`: ADDI 000, ANDI 011, ORI 100, SLTI 101.
  - `extop`=0 for ANDI and ORI.
- IWB: `regwrite`=1, `regdst`=00. → FETCH.
- JUMP: `pcwrite`=1, `pcsrc`=10. → FETCH.
- JAL: `pcwrite`=1, `pcsrc`=10, `regwrite`=1, `regdst`=10, `memtoreg`=10. Captures PC+4 from FETCH. → FETCH.
- Watchdog: an 8-bit counter.
  - Cleared on entry to FETCH, MEMRD and MEMWR, and whenever `mem_ready` is high.
  - Increments each cycle in those states while `mem_ready` is low.
  - When it reaches `WAIT_MAX` with `mem_ready` still low → FAULT with `mem_timeout` set.
- FAULT: all control outputs 0; terminal until reset. The fault flags hold.

## Timing
- Reset, asynchronous: state=IDLE, counter=0, `mem_timeout`=`illegal_op`=0, all control outputs 0.
- Reset asserted mid-instruction aborts the instruction immediately; no write strobe survives past the reset edge.
- Latency with `mem_ready` always high, in cycles excluding IDLE:
  - R-type, ADDI/ANDI/ORI/SLTI, SW: 4.
  - LW: 5.
  - BEQ/BNE, J, JAL: 3.
- Every wait cycle adds 1.
- `mem_ready` is only sampled in FETCH, MEMRD and MEMWR; elsewhere it is ignored.
- `mem_ready` rising on the same cycle the counter reaches `WAIT_MAX`: the access completes and no fault is raised.

## Configuration
- `MAINDEC_JAL_EN` defined: opcode 000011 decodes to the JAL state.
- `MAINDEC_JAL_EN` undefined: the JAL state is absent, 000011 is illegal (→ FAULT, `illegal_op`=1), and `regdst`=10 / `memtoreg`=10 are never driven.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL).
  - `aluop`, `alusrcb`, `memtoreg`, `regdst` and `pcsrc` encodings.
  - The FSM state enum.
- One sub-module, `mem_watchdog`: counter plus compare against `WAIT_MAX`, producing `expire`.

## Test plan
- ADD (op 000000), `mem_ready`=1 throughout: state sequence FETCH, DECODE, RTEXE, ALUWB, FETCH; `regwrite`=1 with `regdst`=01 only in cycle 4.
- LW with `mem_ready` low for 3 cycles in MEMRD: 8 cycles total; `regwrite`=1 with `memtoreg`=01 once; `irwrite` pulses exactly once, in FETCH.
- BNE (000101): BRANCH asserts `branch_ne`=1, `branch`=0, `aluop`=001, `pcsrc`=01; back in FETCH on cycle 4.
- ORI (001101): IEXE drives `extop`=0, `aluop`=100, then IWB writes rt.
- `mem_ready` held low in FETCH with `WAIT_MAX`=15: FAULT after 15 wait cycles, `mem_timeout`=1 sticky; `resetn` pulsed low clears it and the FSM restarts at IDLE.
- Opcode 000011:
  - Macro defined: JAL drives `regdst`=10, `memtoreg`=10, `pcwrite`=1.
  - Macro undefined: FAULT with `illegal_op`=1.
